// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the MEM-stage load/store port.
//               Takes one request at a time over a valid/ready handshake,
//               waits a fixed LATENCY, performs a little-endian byte / half /
//               word access using RISC-V funct3 width encoding and returns the
//               result over a second valid/ready handshake.
// Ports       : clk_i          - clock, rising edge
//               rst_ni         - asynchronous active-low reset
//               req_valid_i    - request present
//               req_ready_o    - responder idle and able to accept
//               req_we_i       - 1 = store, 0 = load
//               req_addr_i     - byte address
//               req_width_i    - funct3 width (B/H/W/BU/HU)
//               req_wdata_i    - store data, right-aligned
//               resp_valid_o   - response present
//               resp_ready_i   - requester takes the response
//               resp_rdata_o   - load result (0 for stores and faults)
//               resp_err_o     - request faulted
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int N       = 17,  // log2 of depth in 32-bit words
  parameter int LATENCY = 2    // accept edge to resp_valid, 1..15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_width_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         DEPTH  = 1 << N;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  width_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0][7:0] mem_q [DEPTH];

  logic        w_accept;
  logic        w_commit;
  logic        c_we;
  logic [31:0] c_addr;
  logic [2:0]  c_width;
  logic [31:0] c_wdata;
  logic        w_err;
  logic [N-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;

  assign req_ready_o  = (state_q == S_IDLE) && rst_ni;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  assign w_accept = req_valid_i && req_ready_o;

  // With a single-cycle latency the access commits on the accept edge itself,
  // so it has to work from the live request; otherwise from the latched copy.
  assign w_commit = (LATENCY == 1) ? w_accept
                                   : ((state_q == S_WAIT) && (cnt_q == 4'd1));

  assign c_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
  assign c_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
  assign c_width = (state_q == S_IDLE) ? req_width_i : width_q;
  assign c_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;

  // Fault detection
  always_comb begin
    w_err = 1'b0;
    if (c_width == 3'b011 || c_width == 3'b110 || c_width == 3'b111) w_err = 1'b1;
    if (c_we && c_width[2])                                      w_err = 1'b1;
    if (c_width[1:0] == 2'b01 && c_addr[0])                      w_err = 1'b1;
    if (c_width == 3'b010 && c_addr[1:0] != 2'b00)               w_err = 1'b1;
    if ((c_addr >> (N + 2)) != 32'd0)                            w_err = 1'b1;
  end

  assign w_idx  = c_addr[N+1:2];
  assign w_word = mem_q[w_idx];
  assign w_byte = w_word[{c_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{c_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = 32'd0;
    case (c_width)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // Replicating the right-aligned store data across the word puts the right
  // bytes on every lane; the byte enables then pick the addressed lanes.
  always_comb begin
    w_be   = 4'b0000;
    w_wrep = c_wdata;
    case (c_width[1:0])
      2'b00: begin
        w_be   = 4'b0001 << c_addr[1:0];
        w_wrep = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = c_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{c_wdata[15:0]}};
      end
      2'b10: begin
        w_be   = 4'b1111;
        w_wrep = c_wdata;
      end
      default: begin
        w_be   = 4'b0000;
        w_wrep = c_wdata;
      end
    endcase
  end

  // Memory array, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (w_commit && c_we && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) mem_q[w_idx][k] <= w_wrep[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_commit) begin
      err_d   = w_err;
      rdata_d = (w_err || c_we) ? 32'd0 : w_load;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      width_q <= 3'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (w_accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        width_q <= req_width_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Two instances
//               (LATENCY=2 and LATENCY=1) share the request/response buses;
//               'sel' steers the handshakes to one of them. Expected results
//               are pushed to a scoreboard on accept and popped on response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_width;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        rdy2, vld2, err2, rdy1, vld1, err1;
  logic [31:0] rd2, rd1;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.N(17), .LATENCY(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid & ~sel), .req_ready_o(rdy2),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_width_i(req_width),
    .req_wdata_i(req_wdata),
    .resp_valid_o(vld2), .resp_ready_i(resp_ready & ~sel),
    .resp_rdata_o(rd2), .resp_err_o(err2)
  );

  dmem_responder #(.N(17), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_width_i(req_width),
    .req_wdata_i(req_wdata),
    .resp_valid_o(vld1), .resp_ready_i(resp_ready & sel),
    .resp_rdata_o(rd1), .resp_err_o(err1)
  );

  assign req_ready  = sel ? rdy1 : rdy2;
  assign resp_valid = sel ? vld1 : vld2;
  assign resp_rdata = sel ? rd1  : rd2;
  assign resp_err   = sel ? err1 : err2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  width;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Starts and ends just after a falling edge. On return the accept edge has
  // passed and the expected result is on the scoreboard.
  task automatic issue(input vec_t v, output bit ok);
    int n = 0;
    req_we    = v.we;
    req_addr  = v.addr;
    req_width = v.width;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      req_valid = 1'b0;
      timeout("accept");
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    sb.push_back('{rdata: v.rdata, err: v.err});
  endtask

  // Called one falling edge after the accept edge; n counts elapsed cycles.
  task automatic wait_resp(output bit ok, output int n);
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = resp_valid;
  endtask

  task automatic collect(input int lat, input int hold);
    bit   ok;
    int   n;
    exp_t e;
    wait_resp(ok, n);
    if (!ok) begin
      timeout("resp_valid");
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    chk("latency", 32'(n), 32'(lat));
    e = sb.pop_front();
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_rdata", resp_rdata, e.rdata);
    end
    chk("rdata", resp_rdata, e.rdata);
    chk("err", {31'd0, resp_err}, {31'd0, e.err});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run(input vec_t v, input int hold);
    bit ok;
    issue(v, ok);
    if (ok) collect(sel ? 1 : 2, hold);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [2:0] w,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.addr = a; v.width = w; v.wdata = wd; v.rdata = rd; v.err = er;
    return v;
  endfunction

  initial begin
    bit   ok;
    int   n;
    exp_t e;

    rst_n      = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_width  = 3'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_ready2", {31'd0, rdy2}, 32'd0);
    chk("rst_valid2", {31'd0, vld2}, 32'd0);
    chk("rst_rdata2", rd2, 32'd0);
    chk("rst_err2",   {31'd0, err2}, 32'd0);
    chk("rst_ready1", {31'd0, rdy1}, 32'd0);
    chk("rst_valid1", {31'd0, vld1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Functional vectors on the LATENCY=2 instance
    vecs.push_back(mk(1, 32'h100, 3'b010, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 32'h100, 3'b010, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h101, 3'b000, 32'h00000080, 32'h0,        0));
    vecs.push_back(mk(0, 32'h101, 3'b000, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h101, 3'b100, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk(0, 32'h100, 3'b010, 32'h0,        32'hDEAD80EF, 0));
    vecs.push_back(mk(1, 32'h102, 3'b001, 32'h00008001, 32'h0,        0));
    vecs.push_back(mk(0, 32'h102, 3'b001, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk(0, 32'h102, 3'b101, 32'h0,        32'h00008001, 0));
    vecs.push_back(mk(0, 32'h100, 3'b010, 32'h0,        32'h800180EF, 0));
    vecs.push_back(mk(0, 32'h100, 3'b001, 32'h0,        32'hFFFF80EF, 0));
    vecs.push_back(mk(0, 32'h100, 3'b000, 32'h0,        32'hFFFFFFEF, 0));
    vecs.push_back(mk(0, 32'h103, 3'b100, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk(0, 32'h103, 3'b001, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 32'h102, 3'b010, 32'h55555555, 32'h0,        1));
    vecs.push_back(mk(0, 32'h100, 3'b010, 32'h0,        32'h800180EF, 0));
    vecs.push_back(mk(0, 32'h100, 3'b011, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 32'h00080000, 3'b010, 32'h0,   32'h0,        1));
    vecs.push_back(mk(1, 32'h104, 3'b100, 32'h000000AA, 32'h0,        1));
    vecs.push_back(mk(1, 32'h104, 3'b010, 32'h00007F7F, 32'h0,        0));
    vecs.push_back(mk(0, 32'h104, 3'b001, 32'h0,        32'h00007F7F, 0));
    vecs.push_back(mk(0, 32'h106, 3'b101, 32'h0,        32'h00000000, 0));
    vecs.push_back(mk(0, 32'h0007FFFC, 3'b010, 32'h0,   32'h0,        0));

    // The last in-range word is written first so its read-back is defined.
    run(mk(1, 32'h0007FFFC, 3'b010, 32'h0, 32'h0, 0), 0);
    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i % 3);

    // Backpressure: a pending request must wait until after the handshake edge
    issue(mk(0, 32'h100, 3'b010, 32'h0, 32'h800180EF, 0), ok);
    if (ok) begin
      wait_resp(ok, n);
      if (!ok) begin
        timeout("bp_resp");
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        req_we = 1'b0; req_addr = 32'h101; req_width = 3'b100; req_wdata = 32'h0;
        req_valid = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("bp_valid", {31'd0, resp_valid}, 32'd1);
          chk("bp_ready", {31'd0, req_ready}, 32'd0);
          chk("bp_rdata", resp_rdata, e.rdata);
          chk("bp_err",   {31'd0, resp_err}, {31'd0, e.err});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
        sb.push_back('{rdata: 32'h00000080, err: 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_accepted", {31'd0, req_ready}, 32'd0);
        collect(2, 0);
      end
    end

    // Reset during WAIT abandons an uncommitted store
    run(mk(1, 32'h200, 3'b010, 32'h12345678, 32'h0, 0), 0);
    req_we = 1'b1; req_addr = 32'h200; req_width = 3'b010; req_wdata = 32'h11111111;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_ready", {31'd0, req_ready}, 32'd0);
    chk("wait_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrst_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(mk(0, 32'h200, 3'b010, 32'h0, 32'h12345678, 0), 0);

    // LATENCY=1: RESP directly, and a store committed before reset is kept
    sel = 1'b1;
    @(negedge clk);
    run(mk(1, 32'h200, 3'b010, 32'hCAFEF00D, 32'h0, 0), 1);
    run(mk(0, 32'h200, 3'b010, 32'h0, 32'hCAFEF00D, 0), 0);
    run(mk(0, 32'h203, 3'b000, 32'h0, 32'hFFFFFFCA, 0), 2);
    req_we = 1'b1; req_addr = 32'h200; req_width = 3'b010; req_wdata = 32'h11111111;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("l1_direct_resp", {31'd0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("l1_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("l1_rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(mk(0, 32'h200, 3'b010, 32'h0, 32'h11111111, 0), 0);

    sel = 1'b0;
    @(negedge clk);
    run(mk(0, 32'h200, 3'b010, 32'h0, 32'h12345678, 0), 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
